// File: rtl/regex_dfa_flow_engine.sv
// ---------------------------------------------------------------------------
// regex_dfa_flow_engine
// Programmable DFA matcher time-shared across NUM_FLOWS byte streams. Each
// flow keeps its current DFA state in a flop-based context array. The
// char-class map, transition table and accept table are loaded at runtime
// through the cfg port.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   char_in/_vld, sof     byte stream (sof restarts the flow at START_STATE)
//   flow_id               flow of char_in/state_in, selects state_out
//   state_in/_vld         context overwrite for flow_id (wins over char_in)
//   state_out             combinational read of ctx[flow_id]
//   accept_out/_flow/_state  registered match report, latency 1
//   cfg_we/sel/addr/data  table writes: 0 charmap, 1 trans, 2 accept
//   match_cnt             saturating count of reported accepts
// ---------------------------------------------------------------------------
module regex_dfa_flow_engine #(
    parameter int STATE_W     = 5,
    parameter int CLASS_W     = 3,
    parameter int FLOW_W      = 4,
    parameter int START_STATE = 0,
    parameter int STICKY      = 0,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic [FLOW_W-1:0]  flow_id,
    input  logic               sof,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_in_vld,
    output logic [STATE_W-1:0] state_out,
    output logic               accept_out,
    output logic [FLOW_W-1:0]  accept_flow,
    output logic [STATE_W-1:0] accept_state,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [15:0]        cfg_addr,
    input  logic [15:0]        cfg_data,
    output logic [CNT_W-1:0]   match_cnt
);
    localparam int NUM_STATES = 2**STATE_W;
    localparam int NUM_FLOWS  = 2**FLOW_W;
    localparam int TRANS_W    = STATE_W + CLASS_W;
    localparam logic [STATE_W-1:0] START = STATE_W'(START_STATE);

    logic [CLASS_W-1:0]    r_charmap [256];
    logic [STATE_W-1:0]    r_trans   [2**TRANS_W];
    logic [NUM_STATES-1:0] r_accept;
    logic [STATE_W-1:0]    r_ctx     [NUM_FLOWS];
    logic [NUM_FLOWS-1:0]  r_flag;

    logic [CLASS_W-1:0] w_cls;
    logic [STATE_W-1:0] w_cur;
    logic [STATE_W-1:0] w_ns;
    logic               w_char;
    logic               w_acc;
    logic               w_cm_ok;
    logic               w_tr_ok;
    logic               w_ac_ok;
    logic               w_unused_cfg;

    // A context overwrite in the same cycle drops the char entirely.
    assign w_char = char_in_vld && !state_in_vld;
    assign w_cls  = r_charmap[char_in];
    assign w_cur  = sof ? START : r_ctx[flow_id];
    assign w_ns   = r_trans[{w_cur, w_cls}];
    // In sticky mode a flow that already reported stays quiet until sof;
    // the sof char itself is allowed to report again.
    assign w_acc  = w_char && r_accept[w_ns] &&
                    !((STICKY != 0) && r_flag[flow_id] && !sof);

    assign state_out = r_ctx[flow_id];

    // Writes with address bits above the table index are dropped.
    assign w_cm_ok = (cfg_addr >> 8) == 16'd0;
    assign w_tr_ok = (cfg_addr >> TRANS_W) == 16'd0;
    assign w_ac_ok = (cfg_addr >> STATE_W) == 16'd0;
    assign w_unused_cfg = ^cfg_data;

    // Tables: the char lookup above reads pre-write contents this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++)        r_charmap[i] <= '0;
            for (int i = 0; i < 2**TRANS_W; i++) r_trans[i]   <= '0;
            r_accept <= '0;
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0: if (w_cm_ok) r_charmap[cfg_addr[7:0]] <= cfg_data[CLASS_W-1:0];
                2'd1: if (w_tr_ok) r_trans[cfg_addr[TRANS_W-1:0]] <= cfg_data[STATE_W-1:0];
                2'd2: if (w_ac_ok) r_accept[cfg_addr[STATE_W-1:0]] <= cfg_data[0];
                default: ;
            endcase
        end
    end

    // Per-flow context and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FLOWS; f++) r_ctx[f] <= START;
            r_flag <= '0;
        end else if (state_in_vld) begin
            r_ctx[flow_id]  <= state_in;
            r_flag[flow_id] <= 1'b0;
        end else if (char_in_vld) begin
            r_ctx[flow_id]  <= w_ns;
            r_flag[flow_id] <= (r_flag[flow_id] && !sof) || w_acc;
        end
    end

    // Match report; flow/state hold their last reported values when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_out   <= 1'b0;
            accept_flow  <= '0;
            accept_state <= '0;
            match_cnt    <= '0;
        end else begin
            accept_out <= w_acc;
            if (w_acc) begin
                accept_flow  <= flow_id;
                accept_state <= w_ns;
                if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_regex_dfa_flow_engine.sv
module tb_regex_dfa_flow_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  char_in = '0;
  logic        char_in_vld = 1'b0;
  logic [3:0]  flow_id = '0;
  logic        sof = 1'b0;
  logic [4:0]  state_in = '0;
  logic        state_in_vld = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;

  logic [4:0]  state_out, state_out_s;
  logic        accept_out, accept_out_s;
  logic [3:0]  accept_flow, accept_flow_s;
  logic [4:0]  accept_state, accept_state_s;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt_s;

  always #5 clk = ~clk;

  // Default engine: non-sticky, 16-bit counter.
  regex_dfa_flow_engine dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_in_vld(char_in_vld),
    .flow_id(flow_id), .sof(sof), .state_in(state_in), .state_in_vld(state_in_vld),
    .state_out(state_out), .accept_out(accept_out), .accept_flow(accept_flow),
    .accept_state(accept_state), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .match_cnt(match_cnt));

  // Sticky engine with a 2-bit counter, fed the same stimulus.
  regex_dfa_flow_engine #(.STICKY(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_in_vld(char_in_vld),
    .flow_id(flow_id), .sof(sof), .state_in(state_in), .state_in_vld(state_in_vld),
    .state_out(state_out_s), .accept_out(accept_out_s), .accept_flow(accept_flow_s),
    .accept_state(accept_state_s), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .match_cnt(match_cnt_s));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tables as plain arrays indexed [state][class].
  int m_cm [256];
  int m_tr [32][8];
  bit m_ac [32];
  int m_ctx [16];
  bit m_flag [16];
  bit e_acc [2];
  int e_flow [2];
  int e_st [2];
  int e_cnt [2];
  int cap [2] = '{65535, 3};

  function automatic void m_clear();
    for (int i = 0; i < 256; i++) m_cm[i] = 0;
    for (int s = 0; s < 32; s++) begin
      m_ac[s] = 0;
      for (int c = 0; c < 8; c++) m_tr[s][c] = 0;
    end
    for (int f = 0; f < 16; f++) begin m_ctx[f] = 0; m_flag[f] = 0; end
    for (int k = 0; k < 2; k++) begin e_acc[k] = 0; e_flow[k] = 0; e_st[k] = 0; e_cnt[k] = 0; end
  endfunction

  task automatic idle_in();
    char_in_vld = 0; sof = 0; state_in_vld = 0; cfg_we = 0;
  endtask

  // One clock with the currently driven inputs; checks comb read before the
  // edge and all registered outputs after it.
  task automatic tick();
    int f, cls, cur, ns, a;
    bit hit [2];
    #1;
    chk("state_out", state_out, m_ctx[flow_id]);
    chk("state_out_s", state_out_s, m_ctx[flow_id]);
    f = flow_id; ns = 0; hit[0] = 0; hit[1] = 0;
    if (char_in_vld && !state_in_vld) begin
      cls = m_cm[char_in];
      cur = sof ? 0 : m_ctx[f];
      ns = m_tr[cur][cls];
      hit[0] = m_ac[ns];
      hit[1] = m_ac[ns] && !(m_flag[f] && !sof);
    end
    @(posedge clk); #1;
    if (state_in_vld) begin
      m_ctx[f] = state_in; m_flag[f] = 0;
    end else if (char_in_vld) begin
      m_ctx[f] = ns;
      if (sof) m_flag[f] = 0;
      if (hit[1]) m_flag[f] = 1;
    end
    if (cfg_we) begin
      a = cfg_addr;
      case (cfg_sel)
        2'd0: if (a < 256) m_cm[a] = cfg_data % 8;
        2'd1: if (a < 256) m_tr[a / 8][a % 8] = cfg_data % 32;
        2'd2: if (a < 32) m_ac[a] = cfg_data[0];
        default: ;
      endcase
    end
    for (int k = 0; k < 2; k++) begin
      e_acc[k] = hit[k];
      if (hit[k]) begin
        e_flow[k] = f; e_st[k] = ns;
        if (e_cnt[k] < cap[k]) e_cnt[k]++;
      end
    end
    chk("acc", accept_out, e_acc[0]);
    chk("acc_flow", accept_flow, e_flow[0]);
    chk("acc_state", accept_state, e_st[0]);
    chk("cnt", match_cnt, e_cnt[0]);
    chk("acc_s", accept_out_s, e_acc[1]);
    chk("acc_flow_s", accept_flow_s, e_flow[1]);
    chk("acc_state_s", accept_state_s, e_st[1]);
    chk("cnt_s", match_cnt_s, e_cnt[1]);
    @(negedge clk);
  endtask

  task automatic send(input int f, input int ch, input bit s);
    flow_id = 4'(f); char_in = 8'(ch); char_in_vld = 1; sof = s;
    tick();
    idle_in();
  endtask

  task automatic cfg(input int sel, input int addr, input int data);
    cfg_we = 1; cfg_sel = 2'(sel); cfg_addr = 16'(addr); cfg_data = 16'(data);
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    #1;
    chk("rst_acc", accept_out, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_cnt_s", match_cnt_s, 0);
    chk("rst_state", state_out, 0);
    m_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic prog_iac();
    for (int c = 0; c < 256; c++) cfg(0, c, (c == 255) ? 1 : (c >= 251) ? 2 : 3);
    for (int a = 0; a < 256; a++) cfg(1, a, (a == 1) ? 1 : (a == 10) ? 2 : 0);
    for (int s = 0; s < 32; s++) cfg(2, s, (s == 2) ? 1 : 0);
  endtask

  initial begin
    m_clear();
    @(negedge clk);
    do_reset();

    // Fresh engine loops in state 0 with no accepts.
    send(0, 8'hFF, 0);
    chk("fresh_acc", accept_out, 0);

    prog_iac();

    // Telnet IAC on flow 3.
    send(3, 8'hFF, 0);
    send(3, 8'hFB, 0);
    chk("iac_acc", accept_out, 1);
    chk("iac_flow", accept_flow, 3);
    chk("iac_state", accept_state, 2);
    chk("iac_cnt", match_cnt, 1);

    // Interleaved flows.
    send(1, 8'hFF, 0);
    send(2, 8'h41, 0);
    send(2, 8'hFF, 0);
    send(1, 8'hFC, 0);
    chk("il_acc1", accept_out, 1);
    chk("il_flow1", accept_flow, 1);
    send(2, 8'hFD, 0);
    chk("il_acc2", accept_out, 1);
    chk("il_flow2", accept_flow, 2);
    chk("il_cnt", match_cnt, 3);

    // Sticky: let state 2 + 0xFF return to 1 so the pattern can re-match.
    cfg(1, 17, 1);
    send(0, 8'hFF, 0);
    send(0, 8'hFB, 0);
    send(0, 8'hFF, 0);
    send(0, 8'hFB, 0);
    chk("stk_plain", accept_out, 1);
    chk("stk_sup", accept_out_s, 0);
    send(0, 8'hFF, 1);
    send(0, 8'hFB, 0);
    chk("stk_sof", accept_out_s, 1);

    // Override beats a same-cycle char.
    flow_id = 5; state_in = 1; state_in_vld = 1; char_in = 8'hFB; char_in_vld = 1;
    tick();
    chk("ovr_acc", accept_out, 0);
    chk("ovr_state", state_out, 1);
    idle_in();
    send(5, 8'hFB, 0);
    chk("ovr_next", accept_out, 1);

    // Config write collides with the completing char.
    send(5, 8'hFF, 1);
    flow_id = 5; char_in = 8'hFB; char_in_vld = 1;
    cfg_we = 1; cfg_sel = 2; cfg_addr = 2; cfg_data = 0;
    tick();
    idle_in();
    chk("col_acc", accept_out, 1);
    send(5, 8'hFF, 1);
    send(5, 8'hFB, 0);
    chk("col_none", accept_out, 0);
    cfg(2, 2, 1);
    cfg(3, 2, 0);        // reserved select
    cfg(2, 16'h0102, 0); // out-of-range address: accept[2] untouched
    send(6, 8'hFF, 0);
    send(6, 8'hFB, 0);
    chk("oor_acc", accept_out, 1);
    chk("sat", match_cnt_s, 3);

    // Reset mid-pattern.
    send(4, 8'hFF, 0);
    do_reset();
    send(4, 8'hFB, 0);
    chk("rst_fb", accept_out, 0);

    // Randomized traffic.
    prog_iac();
    cfg(1, 17, 1);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 7);
      char_in = (r < 3) ? 8'hFF : (r < 6) ? 8'(8'hFB + $urandom_range(0, 3)) : 8'($urandom);
      flow_id = 4'($urandom_range(0, 3));
      char_in_vld = ($urandom_range(0, 9) < 8);
      sof = ($urandom_range(0, 9) == 0);
      state_in_vld = ($urandom_range(0, 19) == 0);
      state_in = 5'($urandom_range(0, 3));
      cfg_we = ($urandom_range(0, 29) == 0);
      cfg_sel = 2'($urandom);
      cfg_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      cfg_data = 16'($urandom_range(0, 3));
      tick();
    end
    idle_in();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
